controle_jogo: RTL and testbench
================================

Name: controle_jogo

Overview:
Game-flow controller for the shooter: sequences start, play, pause, hit-recovery and game-over. It gates entity motion (rodando) and requests an entity reload (reinicia_entidades). It turns the collision levels into once-per-contact score and life events, one check per VGA frame. It drives perdeu into the screen renderer and pontos/vidas to the HEX display path.

Parameters:
VIDAS_INICIAIS, 3, lives loaded on start/restart (1..7)
QUADROS_INVULNERAVEL, 120, frames of invulnerability after ship hit (1..255)

Ports:
CLOCK_50  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high reset
fim_quadro  in  1  one-cycle pulse at end of each VGA frame
iniciar  in  1  level, debounced start key; rising edge detected internally
pausa  in  1  level pause switch
colisao_nave  in  1  level: enemy ball overlaps ship
colisao_inimigo  in  1  level: allied ball overlaps enemy
rodando  out  1  entity update enable
reinicia_entidades  out  1  one-cycle pulse: reload entity positions
perdeu  out  1  game-over flag to renderer
invulneravel  out  1  high during hit recovery (renderer may blink ship)
vidas  out  3  remaining lives, binary
pontos  out  16  score, 4 BCD digits, [15:12] most significant
estado  out  3  state code, debug: 0 INICIO, 1 JOGANDO, 2 ATINGIDO, 3 PAUSADO, 4 PERDEU

Behaviour:
- All outputs are registered and change one cycle after the qualifying input cycle. reinicia_entidades is exactly 1 cycle wide.
- Reset (async, any time, including mid-game or pause) sets: estado INICIO; rodando 0; reinicia_entidades 0; perdeu 0; invulneravel 0; vidas VIDAS_INICIAIS; pontos 0; invulnerability counter 0; collision history regs 0; iniciar history 0; saved return state JOGANDO.
- Start edge: iniciar=1 while its previous-cycle sample is 0.
- rodando=1 only in JOGANDO and ATINGIDO. perdeu=1 only in PERDEU. invulneravel=1 only in ATINGIDO and in PAUSADO when the saved state is ATINGIDO.
- INICIO: start edge -> JOGANDO. Same cycle: reload vidas, clear pontos, clear collision history, pulse reinicia_entidades. pausa is ignored.
- JOGANDO/ATINGIDO, collision sampling: only on fim_quadro. Rise = current level 1 and history bit 0. History bits load the current levels on every fim_quadro in these states only; they are held in other states.
- colisao_inimigo rise: pontos +1 in BCD, with per-digit carry. Saturates at 9999 (stays 9999).
- colisao_nave rise in JOGANDO: if vidas==1 -> vidas 0, go to PERDEU. Else vidas-1, go to ATINGIDO, counter = QUADROS_INVULNERAVEL.
- colisao_nave in ATINGIDO: the history bit updates, but the collision is ignored.
- Both rises on the same fim_quadro: the score increment and the life loss both apply.
- ATINGIDO: each fim_quadro decrements the counter. On a fim_quadro with counter==1 -> counter 0, go to JOGANDO.
- Pause: pausa=1 in JOGANDO/ATINGIDO -> PAUSADO; the current state is saved. Pause has priority: a fim_quadro in the same cycle is not processed, and history and counter are unchanged.
- PAUSADO: counter, pontos, vidas and history are frozen. pausa=0 -> return to the saved state. fim_quadro is ignored.
- PERDEU: vidas 0 and pontos are held for display. Start edge -> same restart actions as from INICIO, to JOGANDO. pausa is ignored.
- iniciar is ignored in JOGANDO, ATINGIDO and PAUSADO.
- Illegal estado codes recover to INICIO on the next clock.

Test Plan:
1. Reset, then iniciar pulse -> 1 cycle later: estado=1, rodando=1, reinicia_entidades high exactly 1 cycle, vidas=3, pontos=0x0000.
2. colisao_inimigo held high across 5 fim_quadro pulses, then low 1 frame, then high 1 frame -> pontos=0x0002. With pontos preset to 0x0099 via 99 rises, the next rise gives 0x0100.
3. colisao_nave rise -> vidas=2, estado=2, invulneravel=1. Further rises for 119 frames leave vidas=2. The 120th fim_quadro returns estado=1 and invulneravel=0.
4. In ATINGIDO with counter=50, pausa=1 coincident with fim_quadro -> estado=3, counter stays 50 across 10 frames. pausa=0 -> estado=2, and 50 more frames are needed to exit.
5. vidas=1 and colisao_nave rise together with colisao_inimigo rise -> pontos+1, vidas=0, estado=4, perdeu=1, rodando=0. Then iniciar -> estado=1, vidas=3, pontos=0.
6. reset asserted mid-PAUSADO, asynchronously between clock edges -> outputs at reset values immediately, without waiting for a clock edge; estado=0.

Source files
------------

// File: rtl/controle_jogo.sv
// Game-flow controller: start, play, pause, hit recovery and game over.
// Turns collision levels into once-per-contact score/life events, evaluated once per VGA frame.
//
//  state    | meaning
//  INICIO   | waiting for the first start edge, entities frozen
//  JOGANDO  | normal play, entities moving, collisions scored
//  ATINGIDO | ship hit, invulnerable for a number of frames
//  PAUSADO  | everything frozen, returns to the saved state
//  PERDEU   | no lives left, score held until a new start edge
module controle_jogo #(
  parameter int VIDAS_INICIAIS       = 3,
  parameter int QUADROS_INVULNERAVEL = 120
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        fim_quadro,
  input  logic        iniciar,
  input  logic        pausa,
  input  logic        colisao_nave,
  input  logic        colisao_inimigo,
  output logic        rodando,
  output logic        reinicia_entidades,
  output logic        perdeu,
  output logic        invulneravel,
  output logic [2:0]  vidas,
  output logic [15:0] pontos,
  output logic [2:0]  estado
);

  typedef enum logic [2:0] {
    INICIO   = 3'd0,
    JOGANDO  = 3'd1,
    ATINGIDO = 3'd2,
    PAUSADO  = 3'd3,
    PERDEU   = 3'd4
  } estado_t;

  localparam logic [2:0] VIDAS_INI = 3'(VIDAS_INICIAIS);
  localparam logic [7:0] QUADROS   = 8'(QUADROS_INVULNERAVEL);

  estado_t     estado_q, estado_d;
  estado_t     salvo_q, salvo_d;
  logic [7:0]  contador_q, contador_d;
  logic [2:0]  vidas_q, vidas_d;
  logic [15:0] pontos_q, pontos_d;
  logic        hist_nave_q, hist_nave_d;
  logic        hist_ini_q, hist_ini_d;
  logic        iniciar_ant_q;
  logic        reinicia_d;
  logic        borda_inicio;
  logic        subida_nave;
  logic        subida_ini;

  assign borda_inicio = iniciar & ~iniciar_ant_q;
  assign subida_nave  = colisao_nave & ~hist_nave_q;
  assign subida_ini   = colisao_inimigo & ~hist_ini_q;

  // BCD +1 with per-digit carry; 9999 saturates.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    estado_d    = estado_q;
    salvo_d     = salvo_q;
    contador_d  = contador_q;
    vidas_d     = vidas_q;
    pontos_d    = pontos_q;
    hist_nave_d = hist_nave_q;
    hist_ini_d  = hist_ini_q;
    reinicia_d  = 1'b0;

    case (estado_q)
      INICIO, PERDEU: begin
        if (borda_inicio) begin
          estado_d    = JOGANDO;
          vidas_d     = VIDAS_INI;
          pontos_d    = 16'h0000;
          hist_nave_d = 1'b0;
          hist_ini_d  = 1'b0;
          contador_d  = 8'd0;
          reinicia_d  = 1'b1;
        end
      end

      JOGANDO, ATINGIDO: begin
        if (pausa) begin
          salvo_d  = estado_q;
          estado_d = PAUSADO;
        end else if (fim_quadro) begin
          hist_nave_d = colisao_nave;
          hist_ini_d  = colisao_inimigo;
          if (subida_ini) begin
            pontos_d = bcd_inc(pontos_q);
          end
          if (estado_q == JOGANDO) begin
            if (subida_nave) begin
              if (vidas_q == 3'd1) begin
                vidas_d  = 3'd0;
                estado_d = PERDEU;
              end else begin
                vidas_d    = vidas_q - 3'd1;
                contador_d = QUADROS;
                estado_d   = ATINGIDO;
              end
            end
          end else if (contador_q <= 8'd1) begin
            contador_d = 8'd0;
            estado_d   = JOGANDO;
          end else begin
            contador_d = contador_q - 8'd1;
          end
        end
      end

      PAUSADO: begin
        if (!pausa) begin
          estado_d = salvo_q;
        end
      end

      default: estado_d = INICIO;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      estado_q           <= INICIO;
      salvo_q            <= JOGANDO;
      contador_q         <= 8'd0;
      vidas_q            <= VIDAS_INI;
      pontos_q           <= 16'h0000;
      hist_nave_q        <= 1'b0;
      hist_ini_q         <= 1'b0;
      iniciar_ant_q      <= 1'b0;
      rodando            <= 1'b0;
      reinicia_entidades <= 1'b0;
      perdeu             <= 1'b0;
      invulneravel       <= 1'b0;
    end else begin
      estado_q           <= estado_d;
      salvo_q            <= salvo_d;
      contador_q         <= contador_d;
      vidas_q            <= vidas_d;
      pontos_q           <= pontos_d;
      hist_nave_q        <= hist_nave_d;
      hist_ini_q         <= hist_ini_d;
      iniciar_ant_q      <= iniciar;
      rodando            <= (estado_d == JOGANDO) || (estado_d == ATINGIDO);
      reinicia_entidades <= reinicia_d;
      perdeu             <= (estado_d == PERDEU);
      invulneravel       <= (estado_d == ATINGIDO) ||
                            ((estado_d == PAUSADO) && (salvo_d == ATINGIDO));
    end
  end

  assign vidas  = vidas_q;
  assign pontos = pontos_q;
  assign estado = estado_q;

endmodule

// File: tb/tb_controle_jogo.sv
// Bench for controle_jogo: directed scenarios plus random traffic, all checked
// against a frame-level game model that keeps score as a plain integer.
module tb_controle_jogo;

  localparam int VIDAS = 3;
  localparam int QUAD  = 120;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        fim_quadro = 1'b0;
  logic        iniciar = 1'b0;
  logic        pausa = 1'b0;
  logic        colisao_nave = 1'b0;
  logic        colisao_inimigo = 1'b0;
  logic        rodando;
  logic        reinicia_entidades;
  logic        perdeu;
  logic        invulneravel;
  logic [2:0]  vidas;
  logic [15:0] pontos;
  logic [2:0]  estado;

  int checks = 0;
  int errors = 0;

  // model: 0 inicio, 1 jogando, 2 atingido, 3 pausado, 4 perdeu
  int m_est, m_salvo, m_vidas, m_pontos, m_timer;
  bit m_hi, m_hn, m_ini_ant, m_reinicia;

  controle_jogo #(.VIDAS_INICIAIS(VIDAS), .QUADROS_INVULNERAVEL(QUAD)) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .fim_quadro(fim_quadro),
    .iniciar(iniciar),
    .pausa(pausa),
    .colisao_nave(colisao_nave),
    .colisao_inimigo(colisao_inimigo),
    .rodando(rodando),
    .reinicia_entidades(reinicia_entidades),
    .perdeu(perdeu),
    .invulneravel(invulneravel),
    .vidas(vidas),
    .pontos(pontos),
    .estado(estado)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_est = 0; m_salvo = 1; m_vidas = VIDAS; m_pontos = 0; m_timer = 0;
    m_hi = 0; m_hn = 0; m_ini_ant = 0; m_reinicia = 0;
  endtask

  task automatic model_step();
    bit borda, sub_i, sub_n;
    borda = iniciar && !m_ini_ant;
    m_ini_ant = iniciar;
    m_reinicia = 0;
    if (m_est == 0 || m_est == 4) begin
      if (borda) begin
        m_est = 1; m_vidas = VIDAS; m_pontos = 0; m_hi = 0; m_hn = 0;
        m_timer = 0; m_reinicia = 1;
      end
    end else if (m_est == 3) begin
      if (!pausa) m_est = m_salvo;
    end else begin
      if (pausa) begin
        m_salvo = m_est;
        m_est = 3;
      end else if (fim_quadro) begin
        sub_i = colisao_inimigo && !m_hi;
        sub_n = colisao_nave && !m_hn;
        m_hi = colisao_inimigo;
        m_hn = colisao_nave;
        if (sub_i && m_pontos < 9999) m_pontos++;
        if (m_est == 1) begin
          if (sub_n) begin
            m_vidas--;
            if (m_vidas == 0) m_est = 4;
            else begin
              m_est = 2;
              m_timer = QUAD;
            end
          end
        end else begin
          m_timer--;
          if (m_timer == 0) m_est = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    check("estado", 16'(estado), 16'(m_est));
    check("rodando", 16'(rodando), 16'(m_est == 1 || m_est == 2));
    check("perdeu", 16'(perdeu), 16'(m_est == 4));
    check("invulneravel", 16'(invulneravel), 16'(m_est == 2 || (m_est == 3 && m_salvo == 2)));
    check("reinicia", 16'(reinicia_entidades), 16'(m_reinicia));
    check("vidas", 16'(vidas), 16'(m_vidas));
    check("pontos", pontos, to_bcd(m_pontos));
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    if (reset) model_reset();
    else model_step();
    #1;
    check_all();
  endtask

  task automatic frame(input logic ci, input logic cn);
    colisao_inimigo = ci;
    colisao_nave = cn;
    fim_quadro = 1'b1;
    tick();
    fim_quadro = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    model_reset();

    // reset state
    tick();
    tick();
    check("reset_estado", 16'(estado), 16'd0);
    check("reset_vidas", 16'(vidas), 16'd3);
    reset = 1'b0;

    // start
    iniciar = 1'b1;
    tick();
    check("start_estado", 16'(estado), 16'd1);
    check("start_reinicia", 16'(reinicia_entidades), 16'd1);
    iniciar = 1'b0;
    tick();
    check("start_reinicia_width", 16'(reinicia_entidades), 16'd0);

    // score once per contact
    for (int i = 0; i < 5; i++) frame(1'b1, 1'b0);
    frame(1'b0, 1'b0);
    frame(1'b1, 1'b0);
    check("score_two", pontos, 16'h0002);
    for (int i = 0; i < 97; i++) begin
      frame(1'b0, 1'b0);
      frame(1'b1, 1'b0);
    end
    check("score_99", pontos, 16'h0099);
    frame(1'b0, 1'b0);
    frame(1'b1, 1'b0);
    check("score_carry", pontos, 16'h0100);

    // ship hit and invulnerability window
    frame(1'b0, 1'b1);
    check("hit_vidas", 16'(vidas), 16'd2);
    check("hit_estado", 16'(estado), 16'd2);
    check("hit_invul", 16'(invulneravel), 16'd1);
    for (int k = 1; k <= 119; k++) frame(1'b0, logic'(k % 2 == 0));
    check("invul_vidas", 16'(vidas), 16'd2);
    check("invul_estado", 16'(estado), 16'd2);
    frame(1'b0, 1'b0);
    check("invul_end_estado", 16'(estado), 16'd1);
    check("invul_end_flag", 16'(invulneravel), 16'd0);

    // pause during hit recovery with 50 frames left
    frame(1'b0, 1'b1);
    for (int k = 0; k < 70; k++) frame(1'b0, 1'b0);
    pausa = 1'b1;
    fim_quadro = 1'b1;
    tick();
    fim_quadro = 1'b0;
    check("pause_estado", 16'(estado), 16'd3);
    check("pause_invul", 16'(invulneravel), 16'd1);
    for (int k = 0; k < 10; k++) frame(1'b0, 1'b0);
    check("paused_hold", 16'(estado), 16'd3);
    pausa = 1'b0;
    tick();
    check("resume_estado", 16'(estado), 16'd2);
    for (int k = 0; k < 49; k++) frame(1'b0, 1'b0);
    check("resume_49", 16'(estado), 16'd2);
    frame(1'b0, 1'b0);
    check("resume_50", 16'(estado), 16'd1);

    // last life lost together with a score
    frame(1'b1, 1'b1);
    check("over_pontos", pontos, 16'h0101);
    check("over_vidas", 16'(vidas), 16'd0);
    check("over_estado", 16'(estado), 16'd4);
    check("over_perdeu", 16'(perdeu), 16'd1);
    check("over_rodando", 16'(rodando), 16'd0);
    pausa = 1'b1;
    tick();
    check("over_pause_ignored", 16'(estado), 16'd4);
    pausa = 1'b0;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    check("restart_estado", 16'(estado), 16'd1);
    check("restart_vidas", 16'(vidas), 16'd3);
    check("restart_pontos", pontos, 16'h0000);
    tick();

    // saturation at 9999
    colisao_nave = 1'b0;
    fim_quadro = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      colisao_inimigo = logic'(i % 2 == 0);
      tick();
    end
    fim_quadro = 1'b0;
    colisao_inimigo = 1'b0;
    check("score_saturate", pontos, 16'h9999);

    // random traffic
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      fim_quadro = logic'($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) colisao_inimigo = logic'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) colisao_nave = logic'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) pausa = ~pausa;
      iniciar = logic'($urandom_range(0, 15) == 0);
      tick();
    end
    fim_quadro = 1'b0;
    iniciar = 1'b0;
    pausa = 1'b0;
    colisao_inimigo = 1'b0;
    colisao_nave = 1'b0;

    // asynchronous reset in the middle of a pause
    do_reset();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    frame(1'b1, 1'b0);
    pausa = 1'b1;
    tick();
    check("pre_reset_estado", 16'(estado), 16'd3);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    check("async_reset_estado", 16'(estado), 16'd0);
    check("async_reset_pontos", pontos, 16'h0000);
    tick();
    reset = 1'b0;
    pausa = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
